// File: rtl/alu_seq_if.sv
// Operand/result bundle for alu_seq.
// master: the requester driving operands and start.
// slave: the ALU returning status and results.
interface alu_seq_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] SrcA;
  logic [WIDTH-1:0] SrcB;
  logic [3:0]       ALUControl;
  logic             start;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] ALUResult;
  logic             Zero_flag;
  logic [WIDTH-1:0] HI;
  logic [WIDTH-1:0] LO;

  modport master (
    output SrcA, SrcB, ALUControl, start,
    input  busy, done, ALUResult, Zero_flag, HI, LO
  );

  modport slave (
    input  SrcA, SrcB, ALUControl, start,
    output busy, done, ALUResult, Zero_flag, HI, LO
  );
endinterface

// File: rtl/alu_seq.sv
// Sequential ALU.
// Single-cycle logic, compare and HI/LO move operations complete in one cycle.
// MULTU is a one-bit-per-cycle shift-add multiply.
// DIVU is a one-bit-per-cycle restoring divide.
// Defining ALU_SEQ_DIV_EN builds the divider. Without it, code 1001 is treated
// as an undefined code.
module alu_seq #(
  parameter int WIDTH = 32
) (
  input  logic       CLK,
  input  logic       RST,
  alu_seq_if.slave   bus
);
  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_XOR   = 4'b0011;
  localparam logic [3:0] OP_SUB   = 4'b0100;
  localparam logic [3:0] OP_MULTU = 4'b0101;
  localparam logic [3:0] OP_SLT   = 4'b0110;
  localparam logic [3:0] OP_NOR   = 4'b0111;
  localparam logic [3:0] OP_SLTU  = 4'b1000;
`ifdef ALU_SEQ_DIV_EN
  localparam logic [3:0] OP_DIVU  = 4'b1001;
`endif
  localparam logic [3:0] OP_MFHI  = 4'b1010;
  localparam logic [3:0] OP_MFLO  = 4'b1011;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MUL  = 2'd1;
`ifdef ALU_SEQ_DIV_EN
  localparam logic [1:0] ST_DIV  = 2'd2;
`endif
  localparam logic [1:0] ST_DONE = 2'd3;

  logic [1:0]       state_r;
  logic             busy_r;
  logic             done_r;
  logic [WIDTH-1:0] result_r;
  logic             zero_r;
  logic [WIDTH-1:0] hi_r;
  logic [WIDTH-1:0] lo_r;
  logic [CNT_W-1:0] cnt_r;
  logic [WIDTH-1:0] opa_r;
  logic [WIDTH-1:0] work_hi_r;
  logic [WIDTH-1:0] work_lo_r;

  logic [WIDTH-1:0] alu_res_s;
  logic             alu_def_s;
  logic             alu_zero_s;
  logic [WIDTH:0]   mul_sum_s;
  logic [WIDTH-1:0] mul_hi_s;
  logic [WIDTH-1:0] mul_lo_s;

`ifdef ALU_SEQ_DIV_EN
  logic [WIDTH-1:0] opb_r;
  logic [WIDTH:0]   div_shift_s;
  logic [WIDTH:0]   div_diff_s;
  logic [WIDTH-1:0] div_hi_s;
  logic [WIDTH-1:0] div_lo_s;
`endif

  assign bus.busy      = busy_r;
  assign bus.done      = done_r;
  assign bus.ALUResult = result_r;
  assign bus.Zero_flag = zero_r;
  assign bus.HI        = hi_r;
  assign bus.LO        = lo_r;

  // Single-cycle result straight from the live inputs; only sampled on a start edge.
  always_comb begin
    alu_res_s = '0;
    alu_def_s = 1'b1;
    case (bus.ALUControl)
      OP_AND:  alu_res_s = bus.SrcA & bus.SrcB;
      OP_OR:   alu_res_s = bus.SrcA | bus.SrcB;
      OP_ADD:  alu_res_s = bus.SrcA + bus.SrcB;
      OP_XOR:  alu_res_s = bus.SrcA ^ bus.SrcB;
      OP_SUB:  alu_res_s = bus.SrcA - bus.SrcB;
      OP_SLT:  alu_res_s = {{(WIDTH-1){1'b0}}, ($signed(bus.SrcA) < $signed(bus.SrcB))};
      OP_NOR:  alu_res_s = ~(bus.SrcA | bus.SrcB);
      OP_SLTU: alu_res_s = {{(WIDTH-1){1'b0}}, (bus.SrcA < bus.SrcB)};
      OP_MFHI: alu_res_s = hi_r;
      OP_MFLO: alu_res_s = lo_r;
      default: begin
        alu_res_s = '0;
        alu_def_s = 1'b0;
      end
    endcase
    alu_zero_s = alu_def_s & (alu_res_s == '0);
  end

  // One shift-add step.
  // The multiplier sits in work_lo and is consumed LSB first.
  // Partial-product bits shift down into work_lo.
  always_comb begin
    mul_sum_s = {1'b0, work_hi_r} + (work_lo_r[0] ? {1'b0, opa_r} : {(WIDTH+1){1'b0}});
    mul_hi_s  = mul_sum_s[WIDTH:1];
    mul_lo_s  = {mul_sum_s[0], work_lo_r[WIDTH-1:1]};
  end

`ifdef ALU_SEQ_DIV_EN
  // One restoring-divide step.
  // The dividend shifts out of work_lo MSB first and quotient bits shift in.
  // A zero divisor never goes negative, so the result is an all-ones quotient
  // and remainder = dividend.
  always_comb begin
    div_shift_s = {work_hi_r, work_lo_r[WIDTH-1]};
    div_diff_s  = div_shift_s - {1'b0, opb_r};
    if (div_diff_s[WIDTH] == 1'b0) begin
      div_hi_s = div_diff_s[WIDTH-1:0];
      div_lo_s = {work_lo_r[WIDTH-2:0], 1'b1};
    end else begin
      div_hi_s = div_shift_s[WIDTH-1:0];
      div_lo_s = {work_lo_r[WIDTH-2:0], 1'b0};
    end
  end
`endif

  // Control FSM, operand capture, iteration and result registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_r   <= ST_IDLE;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      result_r  <= '0;
      zero_r    <= 1'b0;
      hi_r      <= '0;
      lo_r      <= '0;
      cnt_r     <= '0;
      opa_r     <= '0;
      work_hi_r <= '0;
      work_lo_r <= '0;
`ifdef ALU_SEQ_DIV_EN
      opb_r     <= '0;
`endif
    end else begin
      case (state_r)
        ST_IDLE, ST_DONE: begin
          if (bus.start) begin
            if (bus.ALUControl == OP_MULTU) begin
              state_r   <= ST_MUL;
              busy_r    <= 1'b1;
              done_r    <= 1'b0;
              cnt_r     <= '0;
              opa_r     <= bus.SrcA;
              work_hi_r <= '0;
              work_lo_r <= bus.SrcB;
            end
`ifdef ALU_SEQ_DIV_EN
            else if (bus.ALUControl == OP_DIVU) begin
              state_r   <= ST_DIV;
              busy_r    <= 1'b1;
              done_r    <= 1'b0;
              cnt_r     <= '0;
              opb_r     <= bus.SrcB;
              work_hi_r <= '0;
              work_lo_r <= bus.SrcA;
            end
`endif
            else begin
              state_r  <= ST_DONE;
              busy_r   <= 1'b0;
              done_r   <= 1'b1;
              result_r <= alu_res_s;
              zero_r   <= alu_zero_s;
            end
          end else begin
            state_r <= ST_IDLE;
            done_r  <= 1'b0;
          end
        end
        ST_MUL: begin
          work_hi_r <= mul_hi_s;
          work_lo_r <= mul_lo_s;
          if (cnt_r == LAST_STEP) begin
            state_r  <= ST_DONE;
            busy_r   <= 1'b0;
            done_r   <= 1'b1;
            hi_r     <= mul_hi_s;
            lo_r     <= mul_lo_s;
            result_r <= mul_lo_s;
            zero_r   <= (mul_lo_s == '0);
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
`ifdef ALU_SEQ_DIV_EN
        ST_DIV: begin
          work_hi_r <= div_hi_s;
          work_lo_r <= div_lo_s;
          if (cnt_r == LAST_STEP) begin
            state_r  <= ST_DONE;
            busy_r   <= 1'b0;
            done_r   <= 1'b1;
            hi_r     <= div_hi_s;
            lo_r     <= div_lo_s;
            result_r <= div_lo_s;
            zero_r   <= (div_lo_s == '0);
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
`endif
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32: operand/result width, legal range 8 to 64.
REQ-002 The block SHALL have port CLK, input, 1: single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port RST, input, 1: reset, asynchronous, active-high.
REQ-004 The block SHALL have port SrcA, input, WIDTH: operand A.
REQ-005 The block SHALL have port SrcB, input, WIDTH: operand B.
REQ-006 The block SHALL have port ALUControl, input, 4: operation select.
REQ-007 The block SHALL have port start, input, 1: operation request, sampled only when busy=0.
REQ-008 The block SHALL have port busy, output, 1: high while an iterative operation runs.
REQ-009 The block SHALL have port done, output, 1: one-cycle pulse when ALUResult, Zero_flag and HI/LO are valid.
REQ-010 The block SHALL have port ALUResult, output, WIDTH: registered result.
REQ-011 The block SHALL have port Zero_flag, output, 1: registered zero indication.
REQ-012 The block SHALL have ports HI and LO, output, WIDTH each: multiply/divide result registers.

Function
REQ-013 ALUControl encoding SHALL be: 0000 AND, 0001 OR, 0010 ADD, 0011 XOR, 0100 SUB, 0101 MULTU, 0110 SLT (signed), 0111 NOR, 1000 SLTU, 1001 DIVU, 1010 MFHI, 1011 MFLO; all other codes are undefined.
REQ-014 ADD/SUB SHALL wrap modulo 2^WIDTH; SLT/SLTU SHALL yield 1 or 0, zero-extended to WIDTH.
REQ-015 The FSM SHALL have states IDLE, MUL, DIV and DONE; it leaves IDLE only when start=1.
REQ-016 Single-cycle ops (all except MULTU/DIVU): start at edge k → ALUResult/Zero_flag registered at edge k, with done=1 for the cycle after edge k; busy stays 0.
REQ-017 MULTU SHALL be an unsigned shift-add with one bit per cycle: start at edge k → busy=1 after edges k..k+WIDTH-1; at edge k+WIDTH, {HI,LO} = full 2·WIDTH product, ALUResult = LO, busy=0 and done=1 for one cycle.
REQ-018 DIVU SHALL be an unsigned restoring divide with the same timing as REQ-017; LO = quotient, HI = remainder, ALUResult = LO.
REQ-019 For DIVU with SrcB=0, LO SHALL be all ones and HI = SrcA, with normal timing.
REQ-020 Operands and ALUControl SHALL be captured at the start edge; later input changes SHALL NOT affect an operation in progress.
REQ-021 start while busy=1 SHALL be ignored, with no queueing.
REQ-022 start during a done cycle SHALL be accepted (back-to-back operation).
REQ-023 HI/LO SHALL change only on MULTU/DIVU completion; MFHI/MFLO SHALL return HI/LO as of the start edge.
REQ-024 Zero_flag SHALL be 1 iff ALUResult==0 for defined codes.
REQ-025 For undefined codes, ALUResult SHALL be 0 and Zero_flag 0, with single-cycle timing.
REQ-026 ALUResult/Zero_flag SHALL hold their last value between operations.

Reset
REQ-027 RST=1 SHALL immediately force the FSM to IDLE and clear busy, done, ALUResult, Zero_flag, HI, LO and the iteration counter to 0, including mid-operation.
REQ-028 An interrupted operation SHALL produce no done pulse; the first start after RST falls SHALL be accepted.

Configuration
REQ-029 Macro ALU_SEQ_DIV_EN: when defined, DIVU SHALL be implemented per REQ-018/019.
REQ-030 When ALU_SEQ_DIV_EN is undefined, the DIV state and divider logic SHALL be absent, and code 1001 SHALL behave as undefined (REQ-025) with HI/LO unchanged.

Verification (WIDTH=32)
REQ-031 ADD with 0xFFFFFFFF + 1 → after 1 cycle: done pulse, ALUResult=0, Zero_flag=1, busy never set.
REQ-032 MULTU with 0xFFFFFFFF × 0xFFFFFFFF → busy 32 cycles, then done: HI=0xFFFFFFFE, LO=0x00000001, ALUResult=1.
REQ-033 SLT with -1 vs 1 → ALUResult=1; SLTU with the same operands → ALUResult=0, Zero_flag=1.
REQ-034 DIVU with 100/7 → HI=2, LO=14 after 32 busy cycles; DIVU with 5/0 → HI=5, LO=0xFFFFFFFF; without ALU_SEQ_DIV_EN → ALUResult=0, Zero_flag=0, HI/LO unchanged.
REQ-035 MULTU with start held high and operands changing while busy → single result from the captured operands; RST asserted at cycle 10 of a MULTU → all outputs 0 at once and no done pulse.
REQ-036 Undefined code 1111 → ALUResult=0, Zero_flag=0, done after 1 cycle; a start during the done cycle is accepted.
